// File: rtl/lane_unpacker_pkg.sv
// rtl/lane_unpacker_pkg.sv - shared types and staircase lane geometry helpers
package lane_unpacker_pkg;

    typedef enum logic [1:0] {
        RECV = 2'd0,
        DROP = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int unsigned lane_width(input int unsigned base,
                                               input int unsigned step,
                                               input int unsigned i);
        return base + step * i;
    endfunction

    function automatic int unsigned lane_offset(input int unsigned base,
                                                input int unsigned step,
                                                input int unsigned i);
        if (i == 0)
            return 0;
        return base * i + (step * i * (i - 1)) / 2;
    endfunction

    function automatic int unsigned total_bits(input int unsigned lanes,
                                               input int unsigned base,
                                               input int unsigned step);
        return lane_offset(base, step, lanes);
    endfunction

endpackage

// File: rtl/lane_unpacker_lane.sv
// rtl/lane_unpacker_lane.sv - one lane register written a bit at a time
module lane_unpacker_lane #(
    parameter int unsigned W  = 1,
    parameter int unsigned IW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] idx,
    input  logic          d,
    output logic [W-1:0]  q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            for (int b = 0; b < int'(W); b++) begin
                if (idx == IW'(b))
                    q[b] <= d;
            end
        end
    end

endmodule

// File: rtl/lane_unpacker.sv
// rtl/lane_unpacker.sv - serial LSB-first bit stream to packed staircase-lane frame
module lane_unpacker
    import lane_unpacker_pkg::*;
#(
    parameter int unsigned LANES = 3,
    parameter int unsigned BASE  = 1,
    parameter int unsigned STEP  = 2,
    localparam int unsigned TOTAL = total_bits(LANES, BASE, STEP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TOTAL-1:0] out_data,
    output logic [LANES-1:0] out_lane,
    output logic             frame_err
);

    localparam int unsigned LW = $clog2(LANES + 1);
    localparam int unsigned BW = $clog2(BASE + STEP * (LANES - 1) + 1);

    state_t        state, state_n;
    logic [LW-1:0] lane_cnt, lane_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic          err_n;
    logic          take, wr_en, bit_end, last_pos;
    int unsigned   cur_w;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RECV;
            lane_cnt  <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            lane_cnt  <= lane_n;
            bit_cnt   <= bit_n;
            frame_err <= err_n;
        end
    end

    // Counters are already zero while holding, so a bit taken in the drain
    // cycle goes through the same path as a RECV bit at lane 0 bit 0.
    always_comb begin
        state_n  = state;
        lane_n   = lane_cnt;
        bit_n    = bit_cnt;
        err_n    = 1'b0;
        in_ready = (state == HOLD) ? out_ready : 1'b1;
        take     = in_valid && in_ready;
        wr_en    = take && (state != DROP);
        cur_w    = lane_width(BASE, STEP, 32'(lane_cnt));
        bit_end  = (32'(bit_cnt) == cur_w - 1);
        last_pos = (32'(lane_cnt) == LANES - 1) && bit_end;

        case (state)
            RECV, HOLD: begin
                if (state == HOLD && out_ready)
                    state_n = RECV;
                if (take) begin
                    if (last_pos) begin
                        lane_n = '0;
                        bit_n  = '0;
                        if (in_last) begin
                            state_n = HOLD;
                        end else begin
                            err_n   = 1'b1;
                            state_n = DROP;
                        end
                    end else if (in_last) begin
                        err_n   = 1'b1;
                        lane_n  = '0;
                        bit_n   = '0;
                        state_n = RECV;
                    end else if (bit_end) begin
                        bit_n  = '0;
                        lane_n = lane_cnt + LW'(1);
                    end else begin
                        bit_n = bit_cnt + BW'(1);
                    end
                end
            end
            DROP: begin
                if (take && in_last) begin
                    state_n = RECV;
                    lane_n  = '0;
                    bit_n   = '0;
                end
            end
            default: state_n = RECV;
        endcase
    end

    assign out_valid = (state == HOLD);

    always_comb begin
        out_lane = '0;
        for (int i = 0; i < int'(LANES); i++)
            out_lane[i] = (state == RECV) && (lane_cnt == LW'(i));
    end

    for (genvar g = 0; g < int'(LANES); g++) begin : g_lane
        localparam int unsigned OFF = lane_offset(BASE, STEP, g);
        localparam int unsigned W   = lane_width(BASE, STEP, g);

        lane_unpacker_lane #(
            .W  (W),
            .IW (BW)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (wr_en && (lane_cnt == LW'(g))),
            .idx   (bit_cnt),
            .d     (in_bit),
            .q     (out_data[OFF+W-1:OFF])
        );
    end

endmodule
